// File: rtl/ysyx_040750_cache_pkg.sv
// Shared types and constants for the ysyx_040750 cache controllers:
// FSM state encoding, AXI burst/size codes and derived-width helpers.
package ysyx_040750_cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHit,
    StMissAr,
    StRefill,
    StAlloc,
    StMmioAr,
    StMmioR,
    StFence
  } icache_state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

  function automatic int unsigned offt_len(input int unsigned block_size);
    return $clog2(block_size);
  endfunction

  function automatic int unsigned index_len(input int unsigned cache_size,
                                            input int unsigned block_size,
                                            input int unsigned ways);
    return $clog2(cache_size / block_size / ways);
  endfunction

  function automatic int unsigned tag_len(input int unsigned cache_size,
                                          input int unsigned block_size,
                                          input int unsigned ways);
    return 32 - offt_len(block_size) - index_len(cache_size, block_size, ways);
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_040750_icache_tagarray.sv
// I-cache tag store: per-way tags and valid bits, per-set round-robin pointer,
// combinational hit lookup and victim selection for the allocating set.
module ysyx_040750_icache_tagarray
  import ysyx_040750_cache_pkg::*;
#(
  parameter int unsigned SETS      = 64,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned INDEX_LEN = 6,
  parameter int unsigned TAG_LEN   = 21
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic [INDEX_LEN-1:0] I_lookup_index,
  input  logic [TAG_LEN-1:0]   I_lookup_tag,
  output logic [WAYS-1:0]      O_hit_vec,
  input  logic                 I_alloc_en,
  input  logic [INDEX_LEN-1:0] I_alloc_index,
  input  logic [TAG_LEN-1:0]   I_alloc_tag,
  output logic [WAYS-1:0]      O_victim_vec,
  input  logic                 I_invalidate
);

  localparam int unsigned WAY_W = idx_w(WAYS);

  logic [TAG_LEN-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAY_W-1:0]   rr_q    [SETS];

  logic [WAY_W-1:0] victim_idx;
  logic [WAY_W-1:0] rr_next;
  logic             found_invalid;
  logic             all_valid;

  always_comb begin
    O_hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      O_hit_vec[w] = valid_q[I_lookup_index][w] && (tag_q[I_lookup_index][w] == I_lookup_tag);
    end
  end

  // Lowest-numbered invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    victim_idx    = rr_q[I_alloc_index];
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_invalid && !valid_q[I_alloc_index][w]) begin
        victim_idx    = WAY_W'(w);
        found_invalid = 1'b1;
      end
    end
  end

  assign all_valid = &valid_q[I_alloc_index];
  assign rr_next   = (victim_idx == WAY_W'(WAYS - 1)) ? '0 : victim_idx + WAY_W'(1);

  always_comb begin
    O_victim_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      O_victim_vec[w] = (victim_idx == WAY_W'(w));
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
        end
      end
    end else if (I_invalidate) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (I_alloc_en) begin
      valid_q[I_alloc_index][victim_idx] <= 1'b1;
      tag_q[I_alloc_index][victim_idx]   <= I_alloc_tag;
      if (all_valid) begin
        rr_q[I_alloc_index] <= rr_next;
      end
    end
  end

endmodule

// File: rtl/ysyx_040750_icache_nway_ctrl.sv
// N-way set-associative I-cache controller: IFU fetch port, per-way line SRAMs,
// AXI read master for line refills and uncached single-beat MMIO fetches.
module ysyx_040750_icache_nway_ctrl
  import ysyx_040750_cache_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned CACHE_SIZE = 4096,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned MMIO_BIT   = 31,
  localparam int unsigned LINE_W    = BLOCK_SIZE * 8,
  localparam int unsigned SETS      = CACHE_SIZE / BLOCK_SIZE / WAYS,
  localparam int unsigned OFFT_LEN  = offt_len(BLOCK_SIZE),
  localparam int unsigned INDEX_LEN = index_len(CACHE_SIZE, BLOCK_SIZE, WAYS),
  localparam int unsigned TAG_LEN   = tag_len(CACHE_SIZE, BLOCK_SIZE, WAYS)
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic [31:0]            I_cpu_addr,
  input  logic                   I_cpu_rd_req,
  output logic                   O_cpu_rd_ready,
  input  logic                   I_cpu_fencei,
  input  logic                   I_dcache_clean,
  output logic [31:0]            O_cpu_inst,
  output logic                   O_cpu_rvalid,
  input  logic [WAYS*LINE_W-1:0] I_sram_rdata,
  output logic [INDEX_LEN-1:0]   O_sram_addr,
  output logic [WAYS-1:0]        O_sram_cen,
  output logic [WAYS-1:0]        O_sram_wen,
  output logic [LINE_W-1:0]      O_sram_wdata,
  output logic [31:0]            O_mem_araddr,
  output logic                   O_mem_arvalid,
  input  logic                   I_mem_arready,
  output logic [7:0]             O_mem_arlen,
  output logic [2:0]             O_mem_arsize,
  output logic [1:0]             O_mem_arburst,
  input  logic [63:0]            I_mem_rdata,
  input  logic                   I_mem_rvalid,
  input  logic                   I_mem_rlast,
  output logic                   O_mem_rready
);

  localparam int unsigned BEATS  = BLOCK_SIZE / 8;
  localparam int unsigned BEAT_W = idx_w(BEATS);
  localparam int unsigned WORDS  = BLOCK_SIZE / 4;
  localparam int unsigned WORD_W = OFFT_LEN - 2;

  icache_state_e state_q, state_d;

  logic [31:0]        req_addr_q;
  logic [WAYS-1:0]    hit_way_q;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [LINE_W-1:0]  line_q;
  logic               fence_pend_q;

  logic               fence_req;
  logic               accept;
  logic               pc_hs;
  logic               cpu_mmio;
  logic               cpu_hit;
  logic [WAYS-1:0]    hit_vec;
  logic [WAYS-1:0]    victim_vec;
  logic [INDEX_LEN-1:0] cpu_index, req_index;
  logic [TAG_LEN-1:0] cpu_tag, req_tag;
  logic [WORD_W-1:0]  req_word;
  logic [LINE_W-1:0]  hit_line;
  logic [31:0]        hit_word, line_word;

  assign cpu_index = I_cpu_addr[OFFT_LEN +: INDEX_LEN];
  assign cpu_tag   = I_cpu_addr[31 -: TAG_LEN];
  assign req_index = req_addr_q[OFFT_LEN +: INDEX_LEN];
  assign req_tag   = req_addr_q[31 -: TAG_LEN];
  assign req_word  = req_addr_q[OFFT_LEN-1:2];

  // A fence in flight blocks new fetches so none are dropped on the way to StFence.
  assign fence_req      = fence_pend_q | I_cpu_fencei;
  assign accept         = ((state_q == StIdle) || (state_q == StHit)) && !fence_req;
  assign O_cpu_rd_ready = accept;
  assign pc_hs          = I_cpu_rd_req & accept;
  assign cpu_mmio       = ~I_cpu_addr[MMIO_BIT];
  assign cpu_hit        = |hit_vec;
  assign O_mem_rready   = 1'b1;

  ysyx_040750_icache_tagarray #(
    .SETS      (SETS),
    .WAYS      (WAYS),
    .INDEX_LEN (INDEX_LEN),
    .TAG_LEN   (TAG_LEN)
  ) u_tagarray (
    .I_clk          (I_clk),
    .I_rst          (I_rst),
    .I_lookup_index (cpu_index),
    .I_lookup_tag   (cpu_tag),
    .O_hit_vec      (hit_vec),
    .I_alloc_en     (state_q == StAlloc),
    .I_alloc_index  (req_index),
    .I_alloc_tag    (req_tag),
    .O_victim_vec   (victim_vec),
    .I_invalidate   (state_q == StFence)
  );

  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_way_q[w]) begin
        hit_line = I_sram_rdata[w*LINE_W +: LINE_W];
      end
    end
  end

  always_comb begin
    hit_word  = '0;
    line_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (req_word == WORD_W'(i)) begin
        hit_word  = hit_line[32*i +: 32];
        line_word = line_q[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    O_cpu_rvalid  = 1'b0;
    O_cpu_inst    = '0;
    O_sram_addr   = req_index;
    O_sram_cen    = '1;
    O_sram_wen    = '1;
    O_sram_wdata  = line_q;
    O_mem_araddr  = '0;
    O_mem_arvalid = 1'b0;
    O_mem_arlen   = '0;
    O_mem_arsize  = '0;
    O_mem_arburst = '0;

    unique case (state_q)
      StIdle, StHit: begin
        if (state_q == StHit) begin
          O_cpu_rvalid = 1'b1;
          O_cpu_inst   = hit_word;
        end
        O_sram_addr = cpu_index;
        if (fence_req) begin
          state_d = StFence;
        end else if (pc_hs && cpu_mmio) begin
          state_d = StMmioAr;
        end else if (pc_hs && cpu_hit) begin
          state_d    = StHit;
          O_sram_cen = ~hit_vec;
        end else if (pc_hs) begin
          state_d = StMissAr;
        end else begin
          state_d = StIdle;
        end
      end
      StMissAr: begin
        O_mem_arvalid = 1'b1;
        O_mem_araddr  = {req_addr_q[31:OFFT_LEN], {OFFT_LEN{1'b0}}};
        O_mem_arlen   = 8'(BEATS - 1);
        O_mem_arsize  = AXI_SIZE_8B;
        O_mem_arburst = AXI_BURST_INCR;
        beat_d        = '0;
        if (I_mem_arready) begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (I_mem_rvalid) begin
          beat_d = (beat_q == BEAT_W'(BEATS - 1)) ? '0 : beat_q + BEAT_W'(1);
          if (I_mem_rlast) begin
            state_d = StAlloc;
          end
        end
      end
      StAlloc: begin
        O_sram_cen   = ~victim_vec;
        O_sram_wen   = ~victim_vec;
        O_cpu_rvalid = 1'b1;
        O_cpu_inst   = line_word;
        state_d      = StIdle;
      end
      StMmioAr: begin
        O_mem_arvalid = 1'b1;
        O_mem_araddr  = req_addr_q;
        O_mem_arlen   = 8'd0;
        O_mem_arsize  = AXI_SIZE_4B;
        O_mem_arburst = AXI_BURST_FIXED;
        if (I_mem_arready) begin
          state_d = StMmioR;
        end
      end
      StMmioR: begin
        if (I_mem_rvalid && I_mem_rlast) begin
          O_cpu_rvalid = 1'b1;
          O_cpu_inst   = req_addr_q[2] ? I_mem_rdata[63:32] : I_mem_rdata[31:0];
          state_d      = StIdle;
        end
      end
      StFence: begin
        if (I_dcache_clean) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      hit_way_q    <= '0;
      beat_q       <= '0;
      line_q       <= '0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      fence_pend_q <= (state_q == StFence) ? 1'b0 : (fence_pend_q | I_cpu_fencei);
      if (pc_hs) begin
        req_addr_q <= I_cpu_addr;
        hit_way_q  <= hit_vec;
      end
      if ((state_q == StRefill) && I_mem_rvalid) begin
        for (int k = 0; k < BEATS; k++) begin
          if (beat_q == BEAT_W'(k)) begin
            line_q[64*k +: 64] <= I_mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_040750_icache_nway_ctrl.sv
// Randomized self-checking bench for the N-way I-cache controller against an
// array-based cache model and a hashed backing memory.
module tb_ysyx_040750_icache_nway_ctrl;

  localparam int unsigned BLOCK_SIZE = 32;
  localparam int unsigned CACHE_SIZE = 4096;
  localparam int unsigned WAYS       = 2;
  localparam int unsigned LINE_W     = BLOCK_SIZE * 8;
  localparam int unsigned SETS       = CACHE_SIZE / BLOCK_SIZE / WAYS;
  localparam int unsigned OFFT_LEN   = $clog2(BLOCK_SIZE);
  localparam int unsigned INDEX_LEN  = $clog2(SETS);
  localparam int unsigned BEATS      = BLOCK_SIZE / 8;

  logic                   clk;
  logic                   rst;
  logic [31:0]            cpu_addr;
  logic                   cpu_rd_req;
  logic                   cpu_rd_ready;
  logic                   cpu_fencei;
  logic                   dcache_clean;
  logic [31:0]            cpu_inst;
  logic                   cpu_rvalid;
  logic [WAYS*LINE_W-1:0] sram_rdata;
  logic [INDEX_LEN-1:0]   sram_addr;
  logic [WAYS-1:0]        sram_cen;
  logic [WAYS-1:0]        sram_wen;
  logic [LINE_W-1:0]      sram_wdata;
  logic [31:0]            mem_araddr;
  logic                   mem_arvalid;
  logic                   mem_arready;
  logic [7:0]             mem_arlen;
  logic [2:0]             mem_arsize;
  logic [1:0]             mem_arburst;
  logic [63:0]            mem_rdata;
  logic                   mem_rvalid;
  logic                   mem_rlast;
  logic                   mem_rready;

  ysyx_040750_icache_nway_ctrl #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .CACHE_SIZE (CACHE_SIZE),
    .WAYS       (WAYS),
    .MMIO_BIT   (31)
  ) dut (
    .I_clk          (clk),
    .I_rst          (rst),
    .I_cpu_addr     (cpu_addr),
    .I_cpu_rd_req   (cpu_rd_req),
    .O_cpu_rd_ready (cpu_rd_ready),
    .I_cpu_fencei   (cpu_fencei),
    .I_dcache_clean (dcache_clean),
    .O_cpu_inst     (cpu_inst),
    .O_cpu_rvalid   (cpu_rvalid),
    .I_sram_rdata   (sram_rdata),
    .O_sram_addr    (sram_addr),
    .O_sram_cen     (sram_cen),
    .O_sram_wen     (sram_wen),
    .O_sram_wdata   (sram_wdata),
    .O_mem_araddr   (mem_araddr),
    .O_mem_arvalid  (mem_arvalid),
    .I_mem_arready  (mem_arready),
    .O_mem_arlen    (mem_arlen),
    .O_mem_arsize   (mem_arsize),
    .O_mem_arburst  (mem_arburst),
    .I_mem_rdata    (mem_rdata),
    .I_mem_rvalid   (mem_rvalid),
    .I_mem_rlast    (mem_rlast),
    .O_mem_rready   (mem_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line SRAMs: written on cen&wen low, read data valid the cycle after cen low.
  logic [LINE_W-1:0] sram_mem [WAYS][SETS];
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (!sram_cen[w]) begin
        if (!sram_wen[w]) begin
          sram_mem[w][sram_addr] <= sram_wdata;
        end
        sram_rdata[w*LINE_W +: LINE_W] <= sram_mem[w][sram_addr];
      end
    end
  end

  int n_cmp;
  int n_err;

  // Reference cache state
  logic [31:0] m_tag   [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  int          m_rr    [SETS];

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem64(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    return {b ^ 32'h5A5A_1234, (b * 32'h9E37_79B1) ^ 32'h0F0F_7777};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [63:0] d;
    d = mem64(pc);
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  task automatic model_flush();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  // Address phase: random arready stall, request must stay put until accepted.
  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int d;
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      check("ar_hold_valid", mem_arvalid, 1'b1);
      check("ar_hold_addr", mem_araddr, a);
      @(negedge clk);
      #1;
    end
    check("arvalid", mem_arvalid, 1'b1);
    check("araddr", mem_araddr, a);
    check("arlen", mem_arlen, len);
    check("arsize", mem_arsize, size);
    check("arburst", mem_arburst, burst);
    check("rvalid_during_ar", cpu_rvalid, 1'b0);
    mem_arready = 1'b1;
    @(negedge clk);
    mem_arready = 1'b0;
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input bit fence_mid);
    int                 set;
    logic [31:0]        tag;
    bit                 mmio;
    int                 hw;
    int                 v;
    logic [WAYS-1:0]    oh;
    logic [WAYS-1:0]    exp_mask;
    logic [WAYS-1:0]    ones;
    logic [31:0]        line_a;
    logic [LINE_W-1:0]  exp_line;
    logic [INDEX_LEN-1:0] exp_idx;
    set     = int'(pc[OFFT_LEN +: INDEX_LEN]);
    exp_idx = pc[OFFT_LEN +: INDEX_LEN];
    tag     = pc >> (OFFT_LEN + INDEX_LEN);
    mmio    = !pc[31];
    ones    = '1;
    line_a  = pc & ~32'(BLOCK_SIZE - 1);
    hw      = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (hw < 0 && m_valid[set][w] && m_tag[set][w] == tag) hw = w;
    end

    @(negedge clk);
    cpu_addr   = pc;
    cpu_rd_req = 1'b1;
    #1;
    check("rd_ready", cpu_rd_ready, 1'b1);
    if (!mmio && hw >= 0) begin
      oh       = '0;
      oh[hw]   = 1'b1;
      exp_mask = ~oh;
      check("hit_cen", sram_cen, exp_mask);
    end
    @(negedge clk);
    cpu_rd_req = 1'b0;
    #1;

    if (mmio) begin
      ar_phase(pc, 8'd0, 3'd2, 2'b00);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rlast  = 1'b1;
      mem_rdata  = mem64(pc);
      #1;
      check("mmio_rvalid", cpu_rvalid, 1'b1);
      check("mmio_inst", cpu_inst, exp_inst(pc));
      check("mmio_no_alloc", sram_wen, ones);
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
    end else if (hw >= 0) begin
      check("hit_rvalid", cpu_rvalid, 1'b1);
      check("hit_inst", cpu_inst, exp_inst(pc));
      check("hit_no_ar", mem_arvalid, 1'b0);
    end else begin
      ar_phase(line_a, 8'(BEATS - 1), 3'd3, 2'b01);
      for (int k = 0; k < BEATS; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rlast  = (k == BEATS - 1);
        mem_rdata  = mem64(line_a + 32'(8 * k));
        cpu_fencei = fence_mid && (k == 1);
        exp_line[64*k +: 64] = mem64(line_a + 32'(8 * k));
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        cpu_fencei = 1'b0;
      end
      // Model victim: lowest invalid way, else round-robin pointer which then advances.
      v = -1;
      for (int w = 0; w < WAYS; w++) begin
        if (v < 0 && !m_valid[set][w]) v = w;
      end
      if (v < 0) begin
        v = m_rr[set];
        m_rr[set] = (m_rr[set] + 1) % WAYS;
      end
      m_valid[set][v] = 1'b1;
      m_tag[set][v]   = tag;
      oh       = '0;
      oh[v]    = 1'b1;
      exp_mask = ~oh;
      #1;
      check("alloc_rvalid", cpu_rvalid, 1'b1);
      check("alloc_inst", cpu_inst, exp_inst(pc));
      check("alloc_wen", sram_wen, exp_mask);
      check("alloc_cen", sram_cen, exp_mask);
      check("alloc_addr", sram_addr, exp_idx);
      check("alloc_wdata", sram_wdata, exp_line);
      if (fence_mid) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #1;
          check("fence_blocks", cpu_rd_ready, 1'b0);
        end
        dcache_clean = 1'b1;
        @(negedge clk);
        dcache_clean = 1'b0;
        #1;
        check("fence_exit", cpu_rd_ready, 1'b1);
        model_flush();
      end
    end
  endtask

  initial begin
    logic [WAYS-1:0] ones;
    logic [31:0]     pc;
    ones         = '1;
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    cpu_addr     = '0;
    cpu_rd_req   = 1'b0;
    cpu_fencei   = 1'b0;
    dcache_clean = 1'b0;
    mem_arready  = 1'b0;
    mem_rdata    = '0;
    mem_rvalid   = 1'b0;
    mem_rlast    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      for (int s = 0; s < SETS; s++) sram_mem[w][s] = '0;
    end
    model_flush();
    repeat (3) @(negedge clk);
    #1;
    check("rst_rvalid", cpu_rvalid, 1'b0);
    check("rst_arvalid", mem_arvalid, 1'b0);
    check("rst_araddr", mem_araddr, 32'h0);
    check("rst_cen", sram_cen, ones);
    check("rst_wen", sram_wen, ones);
    check("rst_rready", mem_rready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", cpu_rd_ready, 1'b1);

    // Cold miss, then a hit on another word of the same line
    fetch(32'h8000_0004, 1'b0);
    fetch(32'h8000_0008, 1'b0);
    // Four tags into one set: fill way0, way1, then round-robin evictions
    for (int t = 1; t <= 4; t++) fetch(32'h8000_0020 + 32'(t << 11), 1'b0);
    fetch(32'h8000_0020 + 32'(3 << 11) + 32'h4, 1'b0);
    fetch(32'h8000_0020 + 32'(4 << 11) + 32'hC, 1'b0);
    fetch(32'h8000_0020 + 32'(1 << 11), 1'b0);
    // Uncached fetch
    fetch(32'h1000_0004, 1'b0);
    fetch(32'h1000_0000, 1'b0);
    // fence.i during a refill, then the previously cached line must miss
    fetch(32'h8000_1040, 1'b1);
    fetch(32'h8000_0008, 1'b0);

    // Reset mid-burst; stray beats afterwards are ignored
    @(negedge clk);
    cpu_addr   = 32'h8000_0300;
    cpu_rd_req = 1'b1;
    @(negedge clk);
    cpu_rd_req  = 1'b0;
    mem_arready = 1'b1;
    @(negedge clk);
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rlast  = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    #1;
    check("stray_ready", cpu_rd_ready, 1'b1);
    check("stray_rvalid", cpu_rvalid, 1'b0);
    check("stray_arvalid", mem_arvalid, 1'b0);
    check("stray_wen", sram_wen, ones);
    model_flush();
    fetch(32'h8000_0300, 1'b0);

    // Random traffic over a small address pool to mix hits, conflicts and MMIO
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pc = 32'h1000_0000 | 32'($urandom_range(0, 15) << 2);
      end else begin
        pc = 32'h8000_0000 | 32'($urandom_range(0, 3) << (OFFT_LEN + INDEX_LEN))
                           | 32'($urandom_range(0, 3) << OFFT_LEN)
                           | 32'($urandom_range(0, BLOCK_SIZE / 4 - 1) << 2);
      end
      fetch(pc, $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
